polyphase_sum: RTL and testbench
================================

# polyphase_sum

Recombination stage directly downstream of the eight-lane Rx polyphase FIR bank. Aligns the eight independently-timed phase outputs into complete sets, one sample per lane, and sums each set through a pipelined adder tree to produce the decimated Rx output stream. It flags lanes that deliver a second sample before their set has completed.

## Interface
- `LANES`, 8: number of polyphase lanes; fixed power of two, tree depth log2(LANES)=3.
- `DATA_W`, 32: signed lane sample width.
- `OUT_W`, 32: signed output width.
- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `polyphase_output`  in  [LANES-1:0][DATA_W-1:0] signed  per-lane FIR outputs.
- `polyphase_output_tvalid`  in  [LANES-1:0]  per-lane valid, one-cycle strobes, independent timing.
- `sum_tdata`  out  OUT_W signed  recombined sample.
- `sum_tvalid`  out  1  one-cycle strobe per completed set.
- `lane_pending`  out  [LANES-1:0]  lanes holding a sample for the set being assembled.
- `overrun`  out  1  one-cycle pulse when a lane sample is dropped.
- `overrun_sticky`  out  1  set by any overrun; cleared only by reset.

## Operation
- Per lane: capture register `hold[i]` and pending bit `pend[i]` (`lane_pending` = `pend`).
- Set completion in cycle N: `complete = &(pend | tvalid)`.
- Capture, not completing: `tvalid[i] & ~pend[i]` -> load `hold[i]`, set `pend[i]`.
- Overrun, not completing: `tvalid[i] & pend[i]` -> new sample dropped, `hold[i]` kept, `overrun` pulses, `overrun_sticky` set.
- Completing: set operand per lane = `hold[i]` if `pend[i]`, else the live input. After the edge:
  - a lane with `pend & tvalid` reloads `hold[i]` with the live input, and `pend[i]` stays 1; this sample seeds the next set and is not an overrun.
  - all other lanes clear `pend[i]`.
- Adder tree, each stage registered, sign-extended with no loss:
  - stage 1: 4 sums, 33 bits.
  - stage 2: 2 sums, 34 bits.
  - stage 3: 1 sum, 35 bits.
  - stage 4: output register; 35-to-OUT_W reduction per Configuration.
- Valid travels alongside the data in a 4-bit shift register.
- Reset: all `pend`, `hold`, tree registers and the valid pipe go to 0.
  - Outputs during reset: `sum_tdata`=0, `sum_tvalid`=0, `lane_pending`=0, `overrun`=0, `overrun_sticky`=0.
  - Reset mid-operation discards partial sets and in-flight sums; no `sum_tvalid` after deassertion until a fresh full set arrives.

## Timing
- Latency: completing cycle N -> `sum_tvalid`/`sum_tdata` in cycle N+4.
- Throughput: one set per cycle when all lanes are valid every cycle.
- No back-pressure. The FIR bank `tready` is unused; the output must be accepted when valid.
- `overrun` asserts in the cycle after the dropping input cycle (registered).
- `lane_pending` reflects registered state; updates the cycle after capture or completion.

## Configuration
- Macro: `POLYPHASE_SUM_SAT_EN`.
- Defined: stage 4 saturates the 35-bit sum to OUT_W. Clamps to 0x7FFFFFFF / 0x80000000 when OUT_W=32.
- Undefined: stage 4 wraps, taking the low OUT_W bits.
- Latency is identical in both builds.

## Test plan
- Reset, then all 8 lanes valid together with value 1 in cycle N -> `sum_tvalid` in N+4, `sum_tdata`=8, `lane_pending`=0 in N+1.
- Staggered set:
  - lanes 0..7 valid one per cycle in cycles N..N+7, values 10..17 -> single `sum_tvalid` in N+11, `sum_tdata`=108.
  - `lane_pending` counts up 0x01, 0x03, … 0x7F.
- Overrun: lane 2 valid twice (5 then 9) before the other lanes arrive -> `overrun` pulses once, `overrun_sticky`=1, set sum uses 5.
- Simultaneous seed: lanes 0..6 pending, then lane 7 and lane 0 valid in the same cycle with lane 0 = 100 -> set completes with no overrun. `lane_pending`=0x01 after, and the next set includes 100.
- Full scale: all lanes 0x7FFFFFFF.
  - With `POLYPHASE_SUM_SAT_EN` -> `sum_tdata`=0x7FFFFFFF.
  - Without -> `sum_tdata`=0xFFFFFFF8 (low 32 bits of 8×0x7FFFFFFF).
- Reset mid-flight: `rst` asserted in cycle N+2 after a completing cycle N with lanes 0..3 pending -> no `sum_tvalid` at N+4, all outputs 0, `lane_pending`=0.

Source files
------------

// File: rtl/polyphase_sum.sv
// polyphase_sum: recombines the eight Rx polyphase FIR lane outputs into
// complete sets, one sample per lane. Each completed set is summed through a
// registered adder tree to form the decimated output stream.
//
// Optional build macro: POLYPHASE_SUM_SAT_EN
//   defined   -> the output stage saturates the full-precision sum to OUT_W
//   undefined -> the output stage wraps, keeping the low OUT_W bits
// Latency from the completing cycle to sum_tvalid is 4 cycles in both builds.
//
// The tree is three levels deep, so LANES is fixed at 8. OUT_W must not
// exceed DATA_W+3.

module polyphase_sum #(
  parameter int LANES  = 8,
  parameter int DATA_W = 32,
  parameter int OUT_W  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [LANES-1:0][DATA_W-1:0]     polyphase_output,
  input  logic [LANES-1:0]                 polyphase_output_tvalid,
  output logic signed [OUT_W-1:0]          sum_tdata,
  output logic                             sum_tvalid,
  output logic [LANES-1:0]                 lane_pending,
  output logic                             overrun,
  output logic                             overrun_sticky
);

  // Each tree level grows the sum by one bit, so no level can overflow.
  localparam int S1_W = DATA_W + 1;
  localparam int S2_W = DATA_W + 2;
  localparam int S3_W = DATA_W + 3;

  // Per-lane capture state.
  logic [LANES-1:0][DATA_W-1:0] hold;
  logic [LANES-1:0]             pend;

  // Next-state controls for the capture registers.
  logic                         complete;
  logic [LANES-1:0]             pend_next;
  logic [LANES-1:0]             load;
  logic                         drop;
  logic [LANES-1:0][DATA_W-1:0] operand;

  // Adder tree registers and the valid pipe that travels beside them.
  logic [S1_W-1:0]  s1 [LANES/2];
  logic [S2_W-1:0]  s2 [LANES/4];
  logic [S3_W-1:0]  s3;
  logic [OUT_W-1:0] out_q;
  logic [OUT_W-1:0] out_next;
  logic [3:0]       vld;

  // Alignment decision: detect a complete set, pick each lane's operand, and
  // work out which lanes load, stay pending or drop their new sample.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    complete  = &(pend | polyphase_output_tvalid);
    pend_next = pend;
    load      = '0;
    drop      = 1'b0;
    operand   = polyphase_output;
    for (int i = 0; i < LANES; i++) begin
      if (pend[i]) begin
        operand[i] = hold[i];
      end
      if (complete) begin
        // A lane that is both pending and valid seeds the next set; this is
        // not an overrun, its held sample is consumed by the current set.
        load[i]      = pend[i] & polyphase_output_tvalid[i];
        pend_next[i] = pend[i] & polyphase_output_tvalid[i];
      end else begin
        load[i]      = polyphase_output_tvalid[i] & ~pend[i];
        pend_next[i] = pend[i] | polyphase_output_tvalid[i];
        drop         = drop | (polyphase_output_tvalid[i] & pend[i]);
      end
    end
  end

  // Capture registers, pending bits and the overrun flags.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the hold registers are reset even though pend gates their use;
      // a reset must leave no stale lane data behind in any register.
      hold           <= '0;
      pend           <= '0;
      overrun        <= 1'b0;
      overrun_sticky <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (load[i]) begin
          hold[i] <= polyphase_output[i];
        end
      end
      pend    <= pend_next;
      overrun <= drop;
      if (drop) begin
        overrun_sticky <= 1'b1;
      end
    end
  end

  // Output reduction from full precision to OUT_W: saturate or wrap.
  always_comb begin
    out_next = s3[OUT_W-1:0];
`ifdef POLYPHASE_SUM_SAT_EN
    // The sum fits in OUT_W only when every bit above the output sign bit
    // matches the output sign bit.
    if (!((s3[S3_W-1:OUT_W-1] == '0) || (s3[S3_W-1:OUT_W-1] == '1))) begin
      out_next = s3[S3_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                            : {1'b0, {(OUT_W-1){1'b1}}};
    end
`endif
  end

  // Adder tree: three registered levels of sign-extended pairwise sums,
  // then the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < LANES/2; j++) begin
        s1[j] <= '0;
      end
      for (int j = 0; j < LANES/4; j++) begin
        s2[j] <= '0;
      end
      s3    <= '0;
      out_q <= '0;
    end else begin
      for (int j = 0; j < LANES/2; j++) begin
        s1[j] <= {operand[2*j][DATA_W-1], operand[2*j]}
               + {operand[2*j+1][DATA_W-1], operand[2*j+1]};
      end
      for (int j = 0; j < LANES/4; j++) begin
        s2[j] <= {s1[2*j][S1_W-1], s1[2*j]} + {s1[2*j+1][S1_W-1], s1[2*j+1]};
      end
      s3    <= {s2[0][S2_W-1], s2[0]} + {s2[1][S2_W-1], s2[1]};
      out_q <= out_next;
    end
  end

  // Valid pipe: one bit per tree stage, so the strobe lands with its sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld <= {vld[2:0], complete};
    end
  end

  assign sum_tdata    = out_q;
  assign sum_tvalid   = vld[3];
  assign lane_pending = pend;

endmodule

// File: tb/tb_polyphase_sum.sv
// tb_polyphase_sum: directed bench for polyphase_sum. Inputs change 1 time
// unit after a rising edge and outputs are sampled at the same point, so each
// step() advances exactly one cycle. Build with or without
// POLYPHASE_SUM_SAT_EN; the full-scale expectations follow the macro.

module tb_polyphase_sum;

  logic              clk;
  logic              rst;
  logic [7:0][31:0]  data;
  logic [7:0]        tv;
  logic signed [31:0] sum_tdata;
  logic              sum_tvalid;
  logic [7:0]        lane_pending;
  logic              overrun;
  logic              overrun_sticky;

  int checks = 0;
  int errors = 0;

  polyphase_sum dut (
    .clk                     (clk),
    .rst                     (rst),
    .polyphase_output        (data),
    .polyphase_output_tvalid (tv),
    .sum_tdata               (sum_tdata),
    .sum_tvalid              (sum_tvalid),
    .lane_pending            (lane_pending),
    .overrun                 (overrun),
    .overrun_sticky          (overrun_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; valid strobes last a single cycle.
  task automatic step();
    @(posedge clk);
    #1;
    tv = '0;
  endtask

  task automatic set_lane(input int i, input logic [31:0] v);
    data[i] = v;
    tv[i]   = 1'b1;
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int i = 0; i < 8; i++) set_lane(i, v);
  endtask

  initial begin
    rst  = 1'b1;
    data = '0;
    tv   = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    chk("rst_tdata", sum_tdata, 32'd0);
    chk("rst_tvalid", {31'd0, sum_tvalid}, 32'd0);
    chk("rst_pending", {24'd0, lane_pending}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_sticky", {31'd0, overrun_sticky}, 32'd0);
    rst = 1'b0;
    step();

    // All lanes valid together with value 1: sum 8 four cycles later.
    set_all(32'd1);
    step();
    chk("ones_pending_n1", {24'd0, lane_pending}, 32'd0);
    chk("ones_tvalid_n1", {31'd0, sum_tvalid}, 32'd0);
    step();
    step();
    chk("ones_tvalid_n3", {31'd0, sum_tvalid}, 32'd0);
    step();
    chk("ones_tvalid_n4", {31'd0, sum_tvalid}, 32'd1);
    chk("ones_tdata_n4", sum_tdata, 32'd8);
    step();
    chk("ones_tvalid_n5", {31'd0, sum_tvalid}, 32'd0);

    // Staggered set: lane i brings 10+i in cycle N+i; sum 108 in N+11.
    for (int i = 0; i < 8; i++) begin
      set_lane(i, 32'(10 + i));
      step();
      if (i < 7) chk($sformatf("stag_pending_%0d", i), {24'd0, lane_pending},
                     32'((1 << (i + 1)) - 1));
    end
    chk("stag_pending_done", {24'd0, lane_pending}, 32'd0);
    step();
    step();
    chk("stag_tvalid_n10", {31'd0, sum_tvalid}, 32'd0);
    step();
    chk("stag_tvalid_n11", {31'd0, sum_tvalid}, 32'd1);
    chk("stag_tdata_n11", sum_tdata, 32'd108);

    // Overrun: lane 2 sends 5, then 9 before the rest; 9 is dropped.
    set_lane(2, 32'd5);
    step();
    chk("ovr_pending_first", {24'd0, lane_pending}, 32'h04);
    chk("ovr_none_yet", {31'd0, overrun}, 32'd0);
    set_lane(2, 32'd9);
    step();
    chk("ovr_pulse", {31'd0, overrun}, 32'd1);
    chk("ovr_sticky", {31'd0, overrun_sticky}, 32'd1);
    chk("ovr_pending_kept", {24'd0, lane_pending}, 32'h04);
    step();
    chk("ovr_pulse_end", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 8; i++) if (i != 2) set_lane(i, 32'd1);
    step();
    chk("ovr_pending_clear", {24'd0, lane_pending}, 32'd0);
    step();
    step();
    step();
    chk("ovr_tvalid", {31'd0, sum_tvalid}, 32'd1);
    chk("ovr_tdata", sum_tdata, 32'd12);
    chk("ovr_sticky_holds", {31'd0, overrun_sticky}, 32'd1);

    // Simultaneous seed: lanes 0..6 pending, then lane 7 and lane 0 (100)
    // together; the next set takes 100 for lane 0.
    for (int i = 0; i < 7; i++) set_lane(i, 32'd1);
    step();
    chk("seed_pending_7f", {24'd0, lane_pending}, 32'h7F);
    set_lane(7, 32'd2);
    set_lane(0, 32'd100);
    step();
    chk("seed_pending_01", {24'd0, lane_pending}, 32'h01);
    chk("seed_no_overrun", {31'd0, overrun}, 32'd0);
    for (int i = 1; i < 8; i++) set_lane(i, 32'd1);
    step();
    chk("seed_pending_next", {24'd0, lane_pending}, 32'd0);
    chk("seed_no_overrun2", {31'd0, overrun}, 32'd0);
    step();
    chk("seed_tvalid_c3", {31'd0, sum_tvalid}, 32'd0);
    step();
    chk("seed_tvalid_c4", {31'd0, sum_tvalid}, 32'd1);
    chk("seed_tdata_c4", sum_tdata, 32'd9);
    step();
    chk("seed_tvalid_c5", {31'd0, sum_tvalid}, 32'd1);
    chk("seed_tdata_c5", sum_tdata, 32'd107);

    // Back-to-back sets: one result per cycle.
    set_all(32'd2);
    step();
    set_all(32'd3);
    step();
    step();
    step();
    chk("b2b_tvalid_a", {31'd0, sum_tvalid}, 32'd1);
    chk("b2b_tdata_a", sum_tdata, 32'd16);
    step();
    chk("b2b_tvalid_b", {31'd0, sum_tvalid}, 32'd1);
    chk("b2b_tdata_b", sum_tdata, 32'd24);
    step();
    chk("b2b_tvalid_end", {31'd0, sum_tvalid}, 32'd0);

    // Full scale positive and negative.
    set_all(32'h7FFF_FFFF);
    step();
    set_all(32'h8000_0000);
    step();
    step();
    step();
    chk("fs_pos_tvalid", {31'd0, sum_tvalid}, 32'd1);
`ifdef POLYPHASE_SUM_SAT_EN
    chk("fs_pos_tdata", sum_tdata, 32'h7FFF_FFFF);
`else
    chk("fs_pos_tdata", sum_tdata, 32'hFFFF_FFF8);
`endif
    step();
    chk("fs_neg_tvalid", {31'd0, sum_tvalid}, 32'd1);
`ifdef POLYPHASE_SUM_SAT_EN
    chk("fs_neg_tdata", sum_tdata, 32'h8000_0000);
`else
    chk("fs_neg_tdata", sum_tdata, 32'h0000_0000);
`endif

    // Reset mid-flight: lanes 0..3 pending and valid in a completing cycle N,
    // reset in N+2; nothing emerges in N+4.
    for (int i = 0; i < 4; i++) set_lane(i, 32'd1);
    step();
    for (int i = 0; i < 4; i++) set_lane(i, 32'd3);
    for (int i = 4; i < 8; i++) set_lane(i, 32'd1);
    step();
    chk("mid_pending_0f", {24'd0, lane_pending}, 32'h0F);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_tdata", sum_tdata, 32'd0);
    chk("mid_rst_tvalid", {31'd0, sum_tvalid}, 32'd0);
    chk("mid_rst_pending", {24'd0, lane_pending}, 32'd0);
    chk("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    chk("mid_rst_sticky", {31'd0, overrun_sticky}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("mid_tvalid_n4", {31'd0, sum_tvalid}, 32'd0);
    chk("mid_pending_n4", {24'd0, lane_pending}, 32'd0);
    step();
    step();
    chk("mid_tvalid_late", {31'd0, sum_tvalid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
